// File: rtl/wave_pkg.sv
// Shared definitions for the waveform analyzer and its generator-side peers:
// FSM state encodings, default hysteresis and the peak-to-peak helper.
package wave_pkg;

    typedef enum logic [1:0] {
        WAIT_LOW  = 2'd0,
        WAIT_RISE = 2'd1,
        MEASURE   = 2'd2
    } wave_state_e;

    localparam int HYST_DEFAULT = 1024;

    // 17-bit difference so a full-scale swing (-32768 .. 32767) cannot overflow.
    function automatic logic [16:0] peak_to_peak(input logic signed [15:0] mx,
                                                 input logic signed [15:0] mn);
        return {mx[15], mx} - {mn[15], mn};
    endfunction

endpackage

// File: rtl/wave_analyzer_minmax_track.sv
// Running signed maximum/minimum of the samples seen since the last load.
module minmax_track
    import wave_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load_i,
    input  logic               update_i,
    input  logic signed [15:0] sample_i,
    output logic signed [15:0] max_o,
    output logic signed [15:0] min_o
);

    logic signed [15:0] max_q, max_d;
    logic signed [15:0] min_q, min_d;

    // Next extremes: load restarts tracking, update folds in one more sample.
    always_comb begin
        max_d = max_q;
        min_d = min_q;
        if (load_i) begin
            max_d = sample_i;
            min_d = sample_i;
        end else if (update_i) begin
            if (sample_i > max_q) begin
                max_d = sample_i;
            end else begin
                max_d = max_q;
            end
            if (sample_i < min_q) begin
                min_d = sample_i;
            end else begin
                min_d = min_q;
            end
        end else begin
            max_d = max_q;
            min_d = min_q;
        end
    end

    // Extreme registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            max_q <= 16'sd0;
            min_q <= 16'sd0;
        end else begin
            max_q <= max_d;
            min_q <= min_d;
        end
    end

    assign max_o = max_q;
    assign min_o = min_q;

endmodule

// File: rtl/wave_analyzer.sv
// Measures period, extremes and peak-to-peak of a sampled waveform between
// consecutive hysteresis-qualified rising crossings.
module wave_analyzer
    import wave_pkg::*;
#(
    parameter int PERIOD_W = 20,
    parameter int HYST     = HYST_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clk_en,
    input  logic signed [15:0]  sample_in,
    output logic [PERIOD_W-1:0] period_out,
    output logic signed [15:0]  max_out,
    output logic signed [15:0]  min_out,
    output logic [16:0]         pp_out,
    output logic                meas_valid,
    output logic                timeout
);

    localparam logic [PERIOD_W-1:0] CNT_ZERO = {PERIOD_W{1'b0}};
    localparam logic [PERIOD_W-1:0] CNT_ONE  = {{(PERIOD_W-1){1'b0}}, 1'b1};
    localparam logic [PERIOD_W-1:0] CNT_MAX  = {PERIOD_W{1'b1}};
    localparam logic signed [15:0]  HYST_POS = 16'(HYST);
    localparam logic signed [15:0]  HYST_NEG = 16'(0 - HYST);

    wave_state_e         state_q, state_d;
    logic [PERIOD_W-1:0] cnt_q, cnt_d;
    logic                armed_q, armed_d;

    logic                is_low_s, is_high_s;
    logic                publish_s, timeout_s;
    logic                trk_load_s, trk_update_s;
    logic signed [15:0]  trk_value_s;
    logic signed [15:0]  trk_max_s, trk_min_s;

    logic [PERIOD_W-1:0] period_q;
    logic signed [15:0]  max_q, min_q;
    logic [16:0]         pp_q;
    logic                meas_valid_q, timeout_q;

    assign is_low_s  = (sample_in <= HYST_NEG);
    assign is_high_s = (sample_in >= HYST_POS);

    // Crossing detection, sample counting and timeout decisions per enabled sample.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        armed_d      = armed_q;
        publish_s    = 1'b0;
        timeout_s    = 1'b0;
        trk_load_s   = 1'b0;
        trk_update_s = 1'b0;
        trk_value_s  = sample_in;
        if (clk_en) begin
            case (state_q)
                WAIT_LOW: begin
                    cnt_d   = CNT_ZERO;
                    armed_d = 1'b0;
                    if (is_low_s) begin
                        state_d = WAIT_RISE;
                    end else begin
                        state_d = WAIT_LOW;
                    end
                end
                WAIT_RISE: begin
                    if (is_high_s) begin
                        state_d    = MEASURE;
                        cnt_d      = CNT_ONE;
                        armed_d    = 1'b0;
                        trk_load_s = 1'b1;
                    end else if (cnt_q == CNT_MAX) begin
                        timeout_s   = 1'b1;
                        state_d     = WAIT_LOW;
                        cnt_d       = CNT_ZERO;
                        armed_d     = 1'b0;
                        trk_load_s  = 1'b1;
                        trk_value_s = 16'sd0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                MEASURE: begin
                    // A crossing is checked before the counter limit so it wins a tie.
                    if (armed_q && is_high_s) begin
                        publish_s  = 1'b1;
                        cnt_d      = CNT_ONE;
                        armed_d    = 1'b0;
                        trk_load_s = 1'b1;
                    end else if (cnt_q == CNT_MAX) begin
                        timeout_s   = 1'b1;
                        state_d     = WAIT_LOW;
                        cnt_d       = CNT_ZERO;
                        armed_d     = 1'b0;
                        trk_load_s  = 1'b1;
                        trk_value_s = 16'sd0;
                    end else begin
                        cnt_d        = cnt_q + CNT_ONE;
                        trk_update_s = 1'b1;
                        if (is_low_s) begin
                            armed_d = 1'b1;
                        end else begin
                            armed_d = armed_q;
                        end
                    end
                end
                default: begin
                    state_d = WAIT_LOW;
                    cnt_d   = CNT_ZERO;
                    armed_d = 1'b0;
                end
            endcase
        end else begin
            state_d = state_q;
            cnt_d   = cnt_q;
            armed_d = armed_q;
        end
    end

    // FSM state, sample counter and arm flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= WAIT_LOW;
            cnt_q   <= CNT_ZERO;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            armed_q <= armed_d;
        end
    end

    minmax_track u_track (
        .clk      (clk),
        .rst      (rst),
        .load_i   (trk_load_s),
        .update_i (trk_update_s),
        .sample_i (trk_value_s),
        .max_o    (trk_max_s),
        .min_o    (trk_min_s)
    );

    // Published results; the tracker still excludes the crossing sample here.
    always_ff @(posedge clk) begin
        if (rst) begin
            period_q     <= CNT_ZERO;
            max_q        <= 16'sd0;
            min_q        <= 16'sd0;
            pp_q         <= 17'd0;
            meas_valid_q <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            meas_valid_q <= publish_s;
            timeout_q    <= timeout_s;
            if (publish_s) begin
                period_q <= cnt_q;
                max_q    <= trk_max_s;
                min_q    <= trk_min_s;
                pp_q     <= peak_to_peak(trk_max_s, trk_min_s);
            end else begin
                period_q <= period_q;
                max_q    <= max_q;
                min_q    <= min_q;
                pp_q     <= pp_q;
            end
        end
    end

    assign period_out = period_q;
    assign max_out    = max_q;
    assign min_out    = min_q;
    assign pp_out     = pp_q;
    assign meas_valid = meas_valid_q;
    assign timeout    = timeout_q;

endmodule

// File: tb/tb_wave_analyzer.sv
// Scoreboard bench: a sample-list reference model queues expected results,
// a monitor pops and compares them whenever the analyzer pulses.
module tb_wave_analyzer;

    localparam int PW   = 10;
    localparam int HY   = 1024;
    localparam int CMAX = (1 << PW) - 1;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               clk_en = 1'b0;
    logic signed [15:0] sample_in = 16'sd0;
    logic [PW-1:0]      period_out;
    logic signed [15:0] max_out, min_out;
    logic [16:0]        pp_out;
    logic               meas_valid, timeout;

    wave_analyzer #(.PERIOD_W(PW), .HYST(HY)) dut (
        .clk        (clk),
        .rst        (rst),
        .clk_en     (clk_en),
        .sample_in  (sample_in),
        .period_out (period_out),
        .max_out    (max_out),
        .min_out    (min_out),
        .pp_out     (pp_out),
        .meas_valid (meas_valid),
        .timeout    (timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit is_meas;
        int period;
        int mx;
        int mn;
        int pp;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   meas_seen = 0;
    int   to_seen = 0;

    // Reference model: 0 = waiting for a low, 1 = waiting for first rise, 2 = measuring.
    int   phase = 0;
    int   rise_wait = 0;
    bit   armed = 1'b0;
    int   since[$];
    int   last_p = 0, last_mx = 0, last_mn = 0, last_pp = 0;

    function automatic void check(input string name, input longint act, input longint expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, expv, $time);
        end
    endfunction

    function automatic void model_reset();
        phase = 0;
        rise_wait = 0;
        armed = 1'b0;
        since.delete();
        last_p = 0; last_mx = 0; last_mn = 0; last_pp = 0;
    endfunction

    function automatic void model_timeout();
        exp_q.push_back('{1'b0, last_p, last_mx, last_mn, last_pp});
        phase = 0;
        armed = 1'b0;
        since.delete();
    endfunction

    function automatic void model_sample(input int s);
        bit lo, hi;
        int mx, mn;
        lo = (s <= -HY);
        hi = (s >= HY);
        if (phase == 0) begin
            if (lo) begin
                phase = 1;
                rise_wait = 0;
            end
        end else if (phase == 1) begin
            if (hi) begin
                phase = 2;
                since.delete();
                since.push_back(s);
                armed = 1'b0;
            end else if (rise_wait == CMAX) begin
                model_timeout();
            end else begin
                rise_wait++;
            end
        end else begin
            if (armed && hi) begin
                mx = -40000; mn = 40000;
                foreach (since[k]) begin
                    if (since[k] > mx) mx = since[k];
                    if (since[k] < mn) mn = since[k];
                end
                last_p = since.size(); last_mx = mx; last_mn = mn; last_pp = mx - mn;
                exp_q.push_back('{1'b1, last_p, last_mx, last_mn, last_pp});
                since.delete();
                since.push_back(s);
                armed = 1'b0;
            end else if (since.size() == CMAX) begin
                model_timeout();
            end else begin
                since.push_back(s);
                if (lo) armed = 1'b1;
            end
        end
    endfunction

    // Monitor: every pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (meas_valid === 1'b1 || timeout === 1'b1) begin
            check("pulse_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("meas_valid", meas_valid, e.is_meas);
                check("timeout", timeout, !e.is_meas);
                check("period_out", period_out, e.period);
                check("max_out", $signed(max_out), e.mx);
                check("min_out", $signed(min_out), e.mn);
                check("pp_out", pp_out, e.pp);
            end
            if (meas_valid === 1'b1) meas_seen++;
            if (timeout === 1'b1) to_seen++;
        end
    end

    task automatic send(input int s, input int gap);
        repeat (gap) begin
            @(negedge clk);
            clk_en = 1'b0;
        end
        @(negedge clk);
        clk_en = 1'b1;
        sample_in = 16'(s);
        model_sample(s);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            clk_en = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        clk_en = 1'b1;
        sample_in = 16'sd9000;
        @(negedge clk);
        rst = 1'b0;
        clk_en = 1'b0;
        model_reset();
        check("rst_period", period_out, 0);
        check("rst_max", $signed(max_out), 0);
        check("rst_min", $signed(min_out), 0);
        check("rst_pp", pp_out, 0);
        check("rst_meas_valid", meas_valid, 0);
        check("rst_timeout", timeout, 0);
    endtask

    task automatic square(input int hi_v, input int lo_v, input int per, input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            send(((i % per) < per / 2) ? hi_v : lo_v, gap);
        end
    endtask

    task automatic run_len(input int v, input int n);
        for (int i = 0; i < n; i++) send(v, 0);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int m0, t0, per, amp, s;
        do_reset();

        // +/-8000 square, 100 samples per period, one enable every 4 clocks
        m0 = meas_seen;
        square(8000, -8000, 100, 400, 3);
        idle(4);
        check("sq_meas_count", meas_seen - m0, 2);
        check("sq_period", period_out, 100);
        check("sq_max", $signed(max_out), 8000);
        check("sq_min", $signed(min_out), -8000);
        check("sq_pp", pp_out, 16000);

        // A 50-clock enable gap in mid-period must not change the sample count
        m0 = meas_seen;
        for (int i = 0; i < 300; i++) send(((i % 100) < 50) ? 8000 : -8000, (i == 150) ? 50 : 0);
        idle(4);
        check("gap_meas_count", meas_seen - m0, 3);
        check("gap_period", period_out, 100);

        // Full-scale swing
        do_reset();
        square(32767, -32768, 20, 80, 0);
        idle(4);
        check("fs_pp", pp_out, 65535);
        check("fs_max", $signed(max_out), 32767);
        check("fs_min", $signed(min_out), -32768);

        // Randomized noisy squares with random periods, amplitudes and enable gaps
        do_reset();
        for (int seg = 0; seg < 12; seg++) begin
            per = $urandom_range(80, 8);
            amp = $urandom_range(30000, 1100);
            for (int i = 0; i < 2 * per; i++) begin
                s = (((i % per) < per / 2) ? amp : -amp) + int'($urandom_range(1600, 0)) - 800;
                if (s > 32767) s = 32767;
                if (s < -32768) s = -32768;
                send(s, $urandom_range(2, 0));
            end
        end
        idle(4);

        // Constant DC after a valid result: one timeout, results kept
        do_reset();
        square(8000, -8000, 100, 250, 0);
        m0 = meas_seen; t0 = to_seen;
        run_len(5000, 1100);
        idle(4);
        check("dc_timeouts", to_seen - t0, 1);
        check("dc_meas", meas_seen - m0, 0);
        check("dc_period_kept", period_out, 100);
        check("dc_pp_kept", pp_out, 16000);

        // In-band noise: no measurement, one timeout
        square(8000, -8000, 100, 250, 0);
        m0 = meas_seen; t0 = to_seen;
        for (int i = 0; i < 1100; i++) send(int'($urandom_range(1000, 0)) - 500, 0);
        idle(4);
        check("noise_timeouts", to_seen - t0, 1);
        check("noise_meas", meas_seen - m0, 0);

        // Period equal to the counter limit publishes; one longer times out
        do_reset();
        m0 = meas_seen; t0 = to_seen;
        for (int r = 0; r < 3; r++) begin
            run_len(-9000, 600);
            run_len(9000, 423);
        end
        run_len(-9000, 601);
        idle(4);
        check("lim_meas", meas_seen - m0, 2);
        check("lim_timeouts", to_seen - t0, 1);
        check("lim_period", period_out, CMAX);

        // Running sine, reset mid-period: first result needs two rising crossings
        do_reset();
        for (int i = 0; i < 212; i++)
            send($rtoi(20000.0 * $sin(2.0 * 3.14159265358979 * i / 64.0)), 1);
        do_reset();
        m0 = meas_seen;
        for (int i = 212; i < 468; i++) begin
            send($rtoi(20000.0 * $sin(2.0 * 3.14159265358979 * i / 64.0)), 1);
            if (i == 300) check("sine_no_early_meas", meas_seen - m0, 0);
        end
        idle(6);
        check("sine_meas_after_rst", meas_seen - m0, 3);

        idle(10);
        check("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wave_analyzer.md
WAVE_ANALYZER -- requirements
Module: wave_analyzer

Interface
REQ-001 The block SHALL have parameter PERIOD_W, default 20, meaning the period counter width in samples.
REQ-002 The block SHALL have parameter HYST, default 1024, meaning the crossing hysteresis magnitude in LSB (0..16383).
REQ-003 The block SHALL have port clk  input  1  meaning the single system clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst  input  1  meaning the synchronous, active-high reset.
REQ-005 The block SHALL have port clk_en  input  1  meaning the sample strobe; sample_in is valid only when clk_en=1.
REQ-006 The block SHALL have port sample_in  input  16 signed  meaning the waveform sample under measurement.
REQ-007 The block SHALL have port period_out  output  PERIOD_W  meaning the samples between consecutive rising crossings.
REQ-008 The block SHALL have port max_out  output  16 signed  meaning the maximum sample in the last complete period.
REQ-009 The block SHALL have port min_out  output  16 signed  meaning the minimum sample in the last complete period.
REQ-010 The block SHALL have port pp_out  output  17 unsigned  meaning max_out minus min_out.
REQ-011 The block SHALL have port meas_valid  output  1  meaning a one-cycle pulse when the result outputs update.
REQ-012 The block SHALL have port timeout  output  1  meaning a one-cycle pulse when no crossing occurs within the counter range.

Function
REQ-013 The FSM SHALL have states WAIT_LOW, WAIT_RISE and MEASURE, and SHALL evaluate only on cycles with clk_en=1.
REQ-014 A low condition SHALL be sample_in <= -HYST; a high condition SHALL be sample_in >= +HYST (signed compare).
REQ-015 WAIT_LOW SHALL go to WAIT_RISE on a low sample; WAIT_RISE SHALL go to MEASURE on a high sample (first rising crossing: no result published).
REQ-016 In MEASURE, the block SHALL arm on a low sample and treat the next high sample after arming as a rising crossing; samples inside the hysteresis band SHALL change nothing.
REQ-017 At each rising crossing sample the block SHALL set the counter to 1; on every other enabled sample in MEASURE it SHALL increment the counter.
REQ-018 At a rising crossing in MEASURE: period_out = counter, max/min_out = tracked extremes excluding the crossing sample, pp_out = max-min in 17 bits; meas_valid=1 on that same clock edge; trackers SHALL reload with the crossing sample.
REQ-019 Outputs SHALL be registered; meas_valid SHALL be high for exactly one clk cycle regardless of clk_en spacing.
REQ-020 If the counter reaches 2^PERIOD_W-1 in WAIT_RISE/MEASURE, the block SHALL pulse timeout for one cycle, clear counter and trackers, enter WAIT_LOW and keep previous results.
REQ-021 If a timeout and a rising crossing fall on the same sample, the crossing SHALL win (result published, no timeout).
REQ-022 With clk_en=0 the state, counter, trackers and outputs SHALL hold; meas_valid and timeout SHALL be 0.

Reset
REQ-023 Synchronous reset SHALL put the FSM in WAIT_LOW, clear the counter and arm flag, zero all results, and drive meas_valid=0 and timeout=0; rst SHALL dominate clk_en.
REQ-024 A reset mid-period SHALL discard the partial measurement; the first result after reset SHALL need two rising crossings.

Structure
REQ-025 The FSM state encodings and the HYST default SHALL live in a shared package/include wave_pkg, reusable by the generator side.
REQ-026 The min/max tracking SHALL be a sub-module minmax_track (load, update, signed 16-bit max/min).
REQ-027 The block SHALL be a peer of the generator top and SHALL accept any of its 16-bit outputs directly.

Verification
REQ-028 Square wave ±8000, 100 samples per period, clk_en every 4 clk -> period_out=100, max_out=8000, min_out=-8000, pp_out=16000, meas_valid once per period.
REQ-029 ±500 noise around 0 with HYST=1024 -> no meas_valid; timeout after 2^20-1 samples.
REQ-030 Square wave -32768/+32767 -> pp_out=65535 without overflow.
REQ-031 Constant DC 5000 -> no meas_valid; a single timeout pulse; previous results unchanged.
REQ-032 rst asserted for 1 cycle mid-period of a running sine -> outputs zero, and the next meas_valid comes only at the second rising crossing after reset.
REQ-033 clk_en held 0 for 50 clk mid-period -> the period_out count is unaffected (counts samples, not clocks).
